// File: rtl/otter_crypto_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otter_crypto_pkg
// Brief    : Shared types and constants for the OTTER crypto sequencer.
// Revision : 1.0 - initial release
// ============================================================================

package otter_crypto_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_WRITE = 2'd3
    } cseq_state_e;

    localparam logic [6:0] c_OPCODE_ENCRY = 7'b0011100;
    localparam int         c_KEY_SEL_W    = 2;

endpackage : otter_crypto_pkg

`default_nettype wire

// File: rtl/crypto_round_counter.sv
`default_nettype none
// ============================================================================
// Module   : crypto_round_counter
// Brief    : Loadable up/down round counter with terminal-index detection.
// Revision : 1.0 - initial release
// ============================================================================

module crypto_round_counter #(
    parameter int ROUNDS = 32,
    parameter int CNT_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_dir_down,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ROUNDS - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_terminal;

    assign w_terminal = i_dir_down ? (r_count == '0) : (r_count == c_LAST);

    // Terminal check gates the step, so the count never wraps past either end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !w_terminal) begin
            if (i_dir_down) begin
                r_count <= r_count - CNT_W'(1);
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_count    = r_count;
    assign o_terminal = w_terminal;

endmodule : crypto_round_counter

`default_nettype wire

// File: rtl/otter_crypto_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : otter_crypto_sequencer
// Brief    : ENCRY multi-cycle controller: load, ROUNDS rounds, write-back.
// Revision : 1.0 - initial release
// ============================================================================

module otter_crypto_sequencer
    import otter_crypto_pkg::*;
#(
    parameter int ROUNDS = 32,
    parameter int CNT_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                   CSEQ_CLK,
    input  logic                   CSEQ_RESET_N,
    input  logic                   CSEQ_START,
    input  logic                   CSEQ_DECRYPT,
    input  logic                   CSEQ_ABORT,
    output logic                   CSEQ_LOAD_EN,
    output logic                   CSEQ_ROUND_EN,
    output logic [CNT_W-1:0]       CSEQ_ROUND_IDX,
    output logic [c_KEY_SEL_W-1:0] CSEQ_KEY_SEL,
    output logic                   CSEQ_RESULT_WE,
    output logic                   CSEQ_BUSY,
    output logic                   CSEQ_STALL,
    output logic                   CSEQ_DONE
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ROUNDS - 1);

    cseq_state_e      r_state;
    cseq_state_e      w_next_state;
    logic             r_dec;
    logic             w_accept;
    logic [CNT_W-1:0] w_count;
    logic             w_terminal;
    logic [CNT_W-1:0] w_load_val;

    assign w_accept   = (r_state == ST_IDLE) && CSEQ_START && !CSEQ_ABORT;
    assign w_load_val = r_dec ? c_LAST : '0;

    always_ff @(posedge CSEQ_CLK or negedge CSEQ_RESET_N) begin
        if (!CSEQ_RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (CSEQ_ABORT) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = CSEQ_START ? ST_LOAD : ST_IDLE;
                ST_LOAD:  w_next_state = ST_ROUND;
                ST_ROUND: w_next_state = w_terminal ? ST_WRITE : ST_ROUND;
                ST_WRITE: w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // Direction is frozen at accept so later DECRYPT toggles cannot disturb a job.
    always_ff @(posedge CSEQ_CLK or negedge CSEQ_RESET_N) begin
        if (!CSEQ_RESET_N) begin
            r_dec <= 1'b0;
        end else if (CSEQ_ABORT) begin
            r_dec <= 1'b0;
        end else if (w_accept) begin
            r_dec <= CSEQ_DECRYPT;
        end
    end

    crypto_round_counter #(
        .ROUNDS (ROUNDS),
        .CNT_W  (CNT_W)
    ) u_round_counter (
        .clk        (CSEQ_CLK),
        .rst_n      (CSEQ_RESET_N),
        .i_clr      (CSEQ_ABORT),
        .i_load     (r_state == ST_LOAD),
        .i_load_val (w_load_val),
        .i_en       (r_state == ST_ROUND),
        .i_dir_down (r_dec),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    // STALL follows START combinationally in IDLE so the PC holds on the accept cycle.
    always_comb begin
        CSEQ_LOAD_EN   = (r_state == ST_LOAD);
        CSEQ_ROUND_EN  = (r_state == ST_ROUND);
        CSEQ_ROUND_IDX = (r_state == ST_ROUND) ? w_count : '0;
        CSEQ_RESULT_WE = (r_state == ST_WRITE);
        CSEQ_DONE      = (r_state == ST_WRITE);
        CSEQ_BUSY      = (r_state != ST_IDLE);
        CSEQ_STALL     = (r_state == ST_LOAD) || (r_state == ST_ROUND) ||
                         (w_accept && CSEQ_RESET_N);
    end

    generate
        if (CNT_W >= c_KEY_SEL_W) begin : g_keysel_wide
            assign CSEQ_KEY_SEL = CSEQ_ROUND_IDX[c_KEY_SEL_W-1:0];
        end else begin : g_keysel_narrow
            assign CSEQ_KEY_SEL = {{(c_KEY_SEL_W-CNT_W){1'b0}}, CSEQ_ROUND_IDX};
        end
    endgenerate

endmodule : otter_crypto_sequencer

`default_nettype wire

// File: tb/tb_otter_crypto_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_crypto_sequencer
// Brief    : Scoreboard bench for the crypto sequencer (ROUNDS=4 and ROUNDS=1).
// Revision : 1.0 - initial release
// ============================================================================

module tb_otter_crypto_sequencer;

    localparam int R = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n, start, decrypt, abort;
    logic load_en, round_en, result_we, busy, stall, done;
    logic [W-1:0] round_idx;
    logic [1:0]   key_sel;

    logic s1_start, s1_dec, s1_abort;
    logic s1_load_en, s1_round_en, s1_result_we, s1_busy, s1_stall, s1_done;
    logic [0:0] s1_round_idx;
    logic [1:0] s1_key_sel;

    otter_crypto_sequencer #(.ROUNDS(R)) dut (
        .CSEQ_CLK       (clk),
        .CSEQ_RESET_N   (rst_n),
        .CSEQ_START     (start),
        .CSEQ_DECRYPT   (decrypt),
        .CSEQ_ABORT     (abort),
        .CSEQ_LOAD_EN   (load_en),
        .CSEQ_ROUND_EN  (round_en),
        .CSEQ_ROUND_IDX (round_idx),
        .CSEQ_KEY_SEL   (key_sel),
        .CSEQ_RESULT_WE (result_we),
        .CSEQ_BUSY      (busy),
        .CSEQ_STALL     (stall),
        .CSEQ_DONE      (done)
    );

    otter_crypto_sequencer #(.ROUNDS(1)) dut1 (
        .CSEQ_CLK       (clk),
        .CSEQ_RESET_N   (rst_n),
        .CSEQ_START     (s1_start),
        .CSEQ_DECRYPT   (s1_dec),
        .CSEQ_ABORT     (s1_abort),
        .CSEQ_LOAD_EN   (s1_load_en),
        .CSEQ_ROUND_EN  (s1_round_en),
        .CSEQ_ROUND_IDX (s1_round_idx),
        .CSEQ_KEY_SEL   (s1_key_sel),
        .CSEQ_RESULT_WE (s1_result_we),
        .CSEQ_BUSY      (s1_busy),
        .CSEQ_STALL     (s1_stall),
        .CSEQ_DONE      (s1_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 0 = LOAD, 1 = ROUND, 2 = WRITE/DONE
    typedef struct {
        int kind;
        int idx;
        int cyc;
    } ev_t;
    ev_t sb[$];

    always @(negedge clk) begin
        if (load_en || round_en || result_we || done) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {28'd0, load_en, round_en, result_we, done}, 32'd0);
            end else begin
                ev_t e;
                logic [5:0] expv;
                e = sb.pop_front();
                case (e.kind)
                    0:       expv = 6'b100011;
                    1:       expv = 6'b010011;
                    default: expv = 6'b001110;
                endcase
                chk("sb_outputs", {26'd0, load_en, round_en, result_we, done, busy, stall}, {26'd0, expv});
                chk("sb_cycle", cyc, e.cyc);
                if (e.kind == 1) begin
                    chk("sb_round_idx", {30'd0, round_idx}, e.idx);
                    chk("sb_key_sel", {30'd0, key_sel}, e.idx % 4);
                end
            end
        end
    end

    // ab < 0: run to completion; ab = p >= 0: abort during cycle 1+p (0 = LOAD, 1+k = round k).
    task automatic run_job(input bit dec, input int ab, input bit spur, input bit tog);
        int c0, nr, last;
        start   = 1'b1;
        decrypt = dec;
        abort   = 1'b0;
        #1;
        chk("stall_accept", {31'd0, stall}, 32'd1);
        c0 = cyc;
        nr = (ab < 0) ? R : ((ab < R) ? ab : R);
        sb.push_back('{0, 0, c0 + 1});
        for (int k = 0; k < nr; k++)
            sb.push_back('{1, dec ? (R - 1 - k) : k, c0 + 2 + k});
        if (ab < 0)
            sb.push_back('{2, 0, c0 + R + 2});
        last = (ab < 0) ? (R + 2) : (1 + ab);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (tog) decrypt = 1'($urandom);
            if (spur && c == 2) begin
                start   = 1'b1;
                decrypt = ~dec;
            end
            if (ab >= 0 && c == last) abort = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_round_idx", {30'd0, round_idx}, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);
    endtask

    task automatic run_one_round(input bit dec);
        s1_start = 1'b1;
        s1_dec   = dec;
        @(posedge clk); #1;
        s1_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk("r1_load", {31'd0, s1_load_en}, (c == 1) ? 32'd1 : 32'd0);
            chk("r1_round", {31'd0, s1_round_en}, (c == 2) ? 32'd1 : 32'd0);
            chk("r1_done", {30'd0, s1_done, s1_result_we}, (c == 3) ? 32'd3 : 32'd0);
            chk("r1_round_idx", {31'd0, s1_round_idx}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        decrypt  = 1'b0;
        abort    = 1'b0;
        s1_start = 1'b1;
        s1_dec   = 1'b0;
        s1_abort = 1'b0;

        repeat (3) @(negedge clk) begin
            chk("reset_outputs",
                {22'd0, load_en, round_en, round_idx, key_sel, result_we, busy, stall, done}, 32'd0);
            chk("reset_outputs_r1",
                {22'd0, s1_load_en, s1_round_en, s1_round_idx, s1_key_sel, s1_result_we,
                 s1_busy, s1_stall, s1_done}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n    = 1'b1;
        start    = 1'b0;
        s1_start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        run_job(1'b0, -1, 1'b0, 1'b0);
        run_job(1'b1, -1, 1'b0, 1'b1);
        run_job(1'b0, 3, 1'b0, 1'b0);
        run_job(1'b0, -1, 1'b0, 1'b0);
        run_job(1'b0, -1, 1'b1, 1'b0);
        run_job(1'b1, 0, 1'b0, 1'b0);

        start = 1'b1;
        abort = 1'b1;
        #1;
        chk("start_abort_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", {31'd0, busy}, 32'd0);

        for (int j = 0; j < 24; j++) begin
            bit dec, spur, tog;
            int ab;
            dec  = 1'($urandom);
            spur = 1'($urandom);
            tog  = 1'($urandom);
            ab   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(R, 0)) : -1;
            run_job(dec, ab, spur, tog);
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end

        start = 1'b1;
        decrypt = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {22'd0, load_en, round_en, round_idx, key_sel, result_we, busy, stall, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (R + 4) begin @(posedge clk); #1; end
        chk("async_reset_idle", {31'd0, busy}, 32'd0);

        run_one_round(1'b0);
        run_one_round(1'b1);

        run_job(1'b1, -1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("sb_drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_otter_crypto_sequencer

`default_nettype wire

// File: doc/otter_crypto_sequencer.md
# otter_crypto_sequencer

Multi-cycle controller that sequences the OTTER round-based crypto datapath for the ENCRY opcode. It sits between the OTTER control unit FSM and the cipher datapath. On a start request it loads operands, steps the round unit through ROUNDS iterations (forward for encrypt, reverse key order for decrypt) and writes the result back. While it runs, it holds the CPU stalled and blocks interrupt entry.

## Interface
Parameters:
- ROUNDS, default 32: number of cipher rounds; legal range 1..256.
- CNT_W, default $clog2(ROUNDS) with a minimum of 1: width of the round index.

Ports:
- CSEQ_CLK, input, 1: single clock; all state changes on the rising edge.
- CSEQ_RESET_N, input, 1: asynchronous, active-low reset.
- CSEQ_START, input, 1: start request from the CU, raised in EXECUTE when the opcode is ENCRY.
- CSEQ_DECRYPT, input, 1: 1 selects decrypt, 0 selects encrypt; sampled only when START is accepted.
- CSEQ_ABORT, input, 1: synchronous cancel, driven by CU reset or flush.
- CSEQ_LOAD_EN, output, 1: datapath loads its operand registers.
- CSEQ_ROUND_EN, output, 1: datapath performs one round this cycle.
- CSEQ_ROUND_IDX, output, CNT_W: index of the current round.
- CSEQ_KEY_SEL, output, 2: round-key word select, equal to ROUND_IDX[1:0].
- CSEQ_RESULT_WE, output, 1: register-file write strobe for the result.
- CSEQ_BUSY, output, 1: sequencer is not IDLE.
- CSEQ_STALL, output, 1: CU must hold PCWRITE, REGWRITE and interrupt entry.
- CSEQ_DONE, output, 1: one-cycle completion pulse.

## Operation
- States are IDLE, LOAD, ROUND, WRITE.
- IDLE:
  - START=1 with ABORT=0 moves to LOAD and latches DECRYPT into dec_q.
  - All other input combinations stay in IDLE.
- LOAD:
  - LOAD_EN=1.
  - Round counter preloads to 0 when encrypting, or to ROUNDS-1 when decrypting.
  - Next state is ROUND.
- ROUND:
  - ROUND_EN=1 and ROUND_IDX = counter.
  - The counter steps +1 when encrypting and −1 when decrypting.
  - Leaves for WRITE after the cycle whose index is ROUNDS-1 (encrypt) or 0 (decrypt).
  - ROUNDS=1 gives exactly one ROUND cycle.
- WRITE:
  - RESULT_WE=1 and DONE=1 for exactly one cycle.
  - Next state is IDLE.
- BUSY = (state != IDLE).
- STALL = (state ∈ {LOAD, ROUND}) OR (state == IDLE AND START AND NOT ABORT).
  - STALL is combinational on START so the CU does not advance the PC on the accept cycle.
  - STALL is deasserted in WRITE, so the CU advances the PC in the same cycle as RESULT_WE.
- ABORT=1 in any state returns the block to IDLE on the next edge.
  - No RESULT_WE or DONE is issued.
  - Counter is cleared and dec_q is cleared.
  - ABORT has priority over START.
- START while BUSY is ignored; no queueing.
- DECRYPT changes after acceptance have no effect.
- Counter arithmetic is unsigned CNT_W-bit. Terminal compare is done before the step, so the counter never wraps.

## Timing
- Reset (CSEQ_RESET_N=0, applied asynchronously):
  - state=IDLE, counter=0, dec_q=0.
  - All outputs 0, with ROUND_IDX=0 and KEY_SEL=0.
- Reset mid-operation abandons the job immediately; no DONE follows.
- Start is accepted at edge 0:
  - LOAD in cycle 1.
  - ROUND in cycles 2..ROUNDS+1.
  - WRITE/DONE in cycle ROUNDS+2.
  - The next START can be accepted at the edge ending WRITE+1, i.e. in IDLE.
- Total occupancy is ROUNDS+2 cycles. Throughput is one job per ROUNDS+3 cycles.
- All outputs are registered-state decodes except STALL in IDLE.

## Structure
- Package otter_crypto_pkg holds:
  - the state enum, encoded IDLE=0, LOAD=1, ROUND=2, WRITE=3;
  - the ENCRY opcode constant 7'b0011100;
  - the KEY_SEL width.
- Sub-module crypto_round_counter is a CNT_W-bit loadable up/down counter.
  - Inputs: load, load_val, en, dir, clr.
  - Output: terminal flag at ROUNDS-1 (up) or 0 (down).
- The top level contains only the FSM and output decode.

## Test plan
- Reset: hold RESET_N=0 with START=1. All outputs must stay 0. After release with START=0, the block stays IDLE.
- Encrypt, ROUNDS=4, START=1 DECRYPT=0 for one cycle:
  - STALL=1 on the accept cycle.
  - LOAD in cycle 1.
  - ROUND_IDX = 0,1,2,3 and KEY_SEL = 0,1,2,3 in cycles 2–5.
  - DONE=RESULT_WE=1 in cycle 6 only, with STALL=0 in cycle 6.
- Decrypt, ROUNDS=4: ROUND_IDX = 3,2,1,0. DONE in cycle 6. Toggling DECRYPT mid-job has no effect.
- ABORT in ROUND at index 2:
  - IDLE on the next cycle.
  - No DONE or RESULT_WE.
  - ROUND_IDX=0.
  - A subsequent START runs normally.
- Simultaneous events:
  - START+ABORT in IDLE: stays IDLE and STALL=0.
  - START during ROUND: ignored, and exactly one DONE is seen.
  - ROUNDS=1: exactly one ROUND cycle, with DONE in cycle 3.
- Asynchronous reset pulse mid-LOAD, between clock edges: outputs go to 0 immediately and no DONE follows.
